// File: rtl/tt_zbuf_gate.sv
// Sequenced zeroing gate: forces a project-facing bus to zero unless its owner
// has held a settled open request; closing enforces a guard interval before reopen.
module tt_zbuf_gate #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned GUARD   = 2,
    parameter int unsigned REG_OUT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic             en,
    input  logic             kill,
    output logic [WIDTH-1:0] z,
    output logic             open,
    output logic             busy
);

    localparam int unsigned MAXC = (SETTLE > GUARD) ? SETTLE : GUARD;
    localparam int unsigned CW   = (MAXC == 0) ? 1 : $clog2(MAXC + 1);

    localparam logic [1:0] ST_OFF    = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_ON     = 2'd2;
    localparam logic [1:0] ST_GUARD  = 2'd3;

    localparam logic [CW-1:0] C_SETTLE = CW'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [CW-1:0] C_GUARD  = CW'((GUARD > 0) ? GUARD - 1 : 0);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_gate;
    logic          w_req;

    assign w_req = en & ~kill;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_OFF: begin
                if (w_req) begin
                    if (SETTLE > 0) begin
                        w_state_nxt = ST_SETTLE;
                        w_cnt_nxt   = C_SETTLE;
                    end else begin
                        w_state_nxt = ST_ON;
                    end
                end
            end
            ST_SETTLE: begin
                // Abort before opening needs no guard: the bus was never driven.
                if (!w_req) begin
                    w_state_nxt = ST_OFF;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_ON;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_ON: begin
                if (!w_req) begin
                    if (GUARD > 0) begin
                        w_state_nxt = ST_GUARD;
                        w_cnt_nxt   = C_GUARD;
                    end else begin
                        w_state_nxt = ST_OFF;
                    end
                end
            end
            default: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_OFF;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_OFF;
            r_cnt   <= '0;
            r_gate  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gate  <= (w_state_nxt == ST_ON);
        end
    end

    assign busy = (r_state == ST_SETTLE) | (r_state == ST_GUARD);

    // kill is applied after any output register so it always masks in the same cycle.
    if (REG_OUT != 0) begin : g_reg_out
        logic [WIDTH-1:0] r_zr;
        logic             r_gr;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_zr <= '0;
                r_gr <= 1'b0;
            end else begin
                r_zr <= a & {WIDTH{r_gate}};
                r_gr <= r_gate;
            end
        end

        assign z    = r_zr & {WIDTH{~kill}};
        assign open = r_gr & ~kill;
    end else begin : g_comb_out
        assign z    = a & {WIDTH{r_gate & ~kill}};
        assign open = r_gate & ~kill;
    end

endmodule

// File: tb/tb_tt_zbuf_gate.sv
// Directed bench for tt_zbuf_gate: three instances (settled comb, settled registered,
// zero-delay) driven in lockstep, with per-cycle expectations queued and checked.
module tb_tt_zbuf_gate;

    logic       clk = 1'b0;
    logic       rst, en, kill, en2;
    logic [7:0] a;
    logic [7:0] z0, z1, z2;
    logic       open0, open1, open2;
    logic       busy0, busy1, busy2;

    always #5 clk = ~clk;

    tt_zbuf_gate #(.WIDTH(8), .SETTLE(4), .GUARD(2), .REG_OUT(0)) dut0 (
        .clk(clk), .rst(rst), .a(a), .en(en), .kill(kill),
        .z(z0), .open(open0), .busy(busy0)
    );

    tt_zbuf_gate #(.WIDTH(8), .SETTLE(4), .GUARD(2), .REG_OUT(1)) dut1 (
        .clk(clk), .rst(rst), .a(a), .en(en), .kill(kill),
        .z(z1), .open(open1), .busy(busy1)
    );

    tt_zbuf_gate #(.WIDTH(8), .SETTLE(0), .GUARD(0), .REG_OUT(0)) dut2 (
        .clk(clk), .rst(rst), .a(a), .en(en2), .kill(kill),
        .z(z2), .open(open2), .busy(busy2)
    );

    typedef struct {
        string      tag;
        logic [7:0] z0, z1, z2;
        logic       o0, o1, o2;
        logic       b0, b1, b2;
    } exp_t;

    exp_t sb[$];
    int   n_tests;
    int   n_fail;

    // Inputs and expected gate of the previous step (what the next edge samples).
    logic       p_rst, p_g, p_e2, p_k;
    logic [7:0] p_a;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // g/b: expected gate register and busy of the settled instances after this edge.
    task automatic step(input logic [7:0] ai, input logic ei, input logic ki,
                        input logic ri, input logic e2, input logic g, input logic b,
                        input string tag);
        exp_t e;
        logic gr, g2;
        @(posedge clk);
        #1;
        a = ai; en = ei; kill = ki; rst = ri; en2 = e2;
        gr   = p_rst ? 1'b0 : p_g;
        g2   = p_rst ? 1'b0 : (p_e2 & ~p_k);
        e.tag = tag;
        e.o0 = g & ~ki;   e.z0 = e.o0 ? ai  : 8'h00; e.b0 = b;
        e.o1 = gr & ~ki;  e.z1 = e.o1 ? p_a : 8'h00; e.b1 = b;
        e.o2 = g2 & ~ki;  e.z2 = e.o2 ? ai  : 8'h00; e.b2 = 1'b0;
        sb.push_back(e);
        p_rst = ri; p_g = g; p_a = ai; p_e2 = e2; p_k = ki;
        #1;
        e = sb.pop_front();
        chk($sformatf("%s.z0", e.tag), z0, e.z0);
        chk($sformatf("%s.open0", e.tag), {7'd0, open0}, {7'd0, e.o0});
        chk($sformatf("%s.busy0", e.tag), {7'd0, busy0}, {7'd0, e.b0});
        chk($sformatf("%s.z1", e.tag), z1, e.z1);
        chk($sformatf("%s.open1", e.tag), {7'd0, open1}, {7'd0, e.o1});
        chk($sformatf("%s.busy1", e.tag), {7'd0, busy1}, {7'd0, e.b1});
        chk($sformatf("%s.z2", e.tag), z2, e.z2);
        chk($sformatf("%s.open2", e.tag), {7'd0, open2}, {7'd0, e.o2});
        chk($sformatf("%s.busy2", e.tag), {7'd0, busy2}, {7'd0, e.b2});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pat;
        n_tests = 0; n_fail = 0;
        rst = 1'b1; a = 8'hFF; en = 1'b1; kill = 1'b0; en2 = 1'b0;
        p_rst = 1'b1; p_g = 1'b0; p_e2 = 1'b0; p_k = 1'b0; p_a = 8'h00;

        // Reset held with data and request active, then released
        step(8'hFF, 1, 0, 1, 0, 0, 0, "rst_hold0");
        step(8'hFF, 1, 0, 1, 0, 0, 0, "rst_hold1");
        step(8'hFF, 1, 0, 0, 0, 0, 0, "rst_rel");
        for (int i = 0; i < 4; i++) step(8'hA5, 1, 0, 0, 0, 0, 1, "settle");
        step(8'hA5, 1, 0, 0, 0, 1, 0, "open");
        step(8'h3C, 1, 0, 0, 0, 1, 0, "on_a");
        step(8'h96, 1, 0, 0, 0, 1, 0, "on_b");

        // Close then guard; request held high through guard is not honoured early
        step(8'h5A, 0, 0, 0, 0, 1, 0, "close_req");
        step(8'h5A, 1, 0, 0, 0, 0, 1, "guard0");
        step(8'h5A, 1, 0, 0, 0, 0, 1, "guard1");
        step(8'h5A, 1, 0, 0, 0, 0, 0, "guard_off");
        for (int i = 0; i < 4; i++) step(8'h5A, 1, 0, 0, 0, 0, 1, "reopen_settle");
        step(8'h5A, 1, 0, 0, 0, 1, 0, "reopen");

        // Kill while ON: masks in the same cycle, then guard and settle before reopen
        step(8'h3C, 1, 1, 0, 0, 1, 0, "kill");
        step(8'h3C, 1, 0, 0, 0, 0, 1, "kguard0");
        step(8'h3C, 1, 1, 0, 0, 0, 1, "kguard1");
        step(8'h3C, 1, 0, 0, 0, 0, 0, "kguard_off");
        for (int i = 0; i < 4; i++) step(8'h3C, 1, 0, 0, 0, 0, 1, "ksettle");
        step(8'h3C, 1, 0, 0, 0, 1, 0, "kreopen");

        // Request pulse of three samples aborts settle without a guard
        step(8'hC3, 0, 0, 0, 0, 1, 0, "ab_close");
        step(8'hC3, 0, 0, 0, 0, 0, 1, "ab_g0");
        step(8'hC3, 0, 0, 0, 0, 0, 1, "ab_g1");
        step(8'hC3, 1, 0, 0, 0, 0, 0, "ab_off");
        step(8'hC3, 1, 0, 0, 0, 0, 1, "ab_s3");
        step(8'hC3, 1, 0, 0, 0, 0, 1, "ab_s2");
        step(8'hC3, 0, 0, 0, 0, 0, 1, "ab_s1");
        step(8'hC3, 0, 0, 0, 0, 0, 0, "ab_abort");
        step(8'hC3, 0, 0, 0, 0, 0, 0, "ab_idle");

        // Kill during settle aborts; kill with request in OFF blocks the request
        step(8'hC3, 1, 0, 0, 0, 0, 0, "ks_req");
        step(8'hC3, 1, 1, 0, 0, 0, 1, "ks_settle");
        step(8'hC3, 1, 1, 0, 0, 0, 0, "ks_killed");
        step(8'hC3, 0, 0, 0, 0, 0, 0, "ko_blocked");

        // Zero settle/guard instance: open tracks the sampled request, never busy
        pat = 8'b0100_1101;
        for (int i = 0; i < 8; i++)
            step(8'(i * 17 + 3), 0, (i == 3), 0, pat[i], 0, 0, "degen");

        // Reset while ON closes everything with no guard
        step(8'h81, 1, 0, 0, 1, 0, 0, "ron_req");
        for (int i = 0; i < 4; i++) step(8'h81, 1, 0, 0, 1, 0, 1, "ron_settle");
        step(8'h81, 1, 0, 1, 1, 1, 0, "ron_rst");
        step(8'h81, 0, 0, 0, 0, 0, 0, "ron_after");
        step(8'h81, 0, 0, 0, 0, 0, 0, "ron_noguard");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
